proc_sequencer: RTL and testbench
=================================

Name: proc_sequencer

Overview:
- Instruction issuer for the 9-bit bus processor: the initiator side of its DIN/Run/Done interface.
- Fetches program words from a synchronous-read program memory and presents each instruction on DIN with a one-cycle Run pulse.
- Supplies the immediate word for mvi, waits for Done, then advances the PC.
- Stops on a HALT opcode; flags Error on an illegal opcode or a Done timeout.

Parameters:
- ADDR_W, 7, program memory address width; PC wraps modulo 2^ADDR_W.
- TIMEOUT, 8, maximum EXEC cycles allowed without Done before Error.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  reset, asynchronous, active-low.
- Start  in  1  begin execution at StartAddr; sampled only in IDLE, HALTED or ERROR.
- StartAddr  in  ADDR_W  initial PC.
- MemAddr  out  ADDR_W  program memory read address.
- MemData  in  9  program word; valid the cycle after MemAddr (1-cycle latency).
- DIN  out  9  instruction or immediate word to the processor (registered).
- Run  out  1  one-cycle issue strobe to the processor.
- Done  in  1  processor completion, combinational from the processor.
- Busy  out  1  high in FETCH, LOAD, PRE, ISSUE, EXEC.
- Halted  out  1  high in HALTED.
- Error  out  1  high in ERROR.
- PC  out  ADDR_W  current program counter.
- InstrCount  out  CNT_W  instructions retired since the last Start.

Behaviour:
- Opcodes are IR[8:6]:
  - 000 mv, 001 mvi, 010 add, 011 sub, 100 ones: issued to the processor.
  - 111 HALT: consumed locally, never issued.
  - 101, 110: illegal.
- States: IDLE, FETCH, LOAD, PRE, ISSUE, EXEC, HALTED, ERROR.
- Reset values: state IDLE, PC=0, DIN=0, Run=0, MemAddr=0, InstrCount=0, instruction and immediate registers 0, Busy/Halted/Error=0.
- Reset mid-operation aborts immediately with no further Run. The processor shares Resetn.
- IDLE / HALTED / ERROR:
  - On Start=1: PC<=StartAddr, InstrCount<=0, go to FETCH.
  - Otherwise hold.
- FETCH: MemAddr=PC. Go to LOAD.
- LOAD: InstrReg<=MemData; MemAddr=PC+1 (wraps). Go to PRE.
- PRE:
  - ImmReg<=MemData.
  - Opcode 111: go to HALTED; PC unchanged, pointing at the HALT word.
  - Opcode 101/110: go to ERROR.
  - Otherwise go to ISSUE.
- ISSUE:
  - DIN=InstrReg and Run=1 for exactly this cycle; the processor latches IR at the end of this cycle.
  - Watchdog is cleared. Go to EXEC.
- EXEC:
  - Run=0.
  - DIN=ImmReg when opcode is 001, else DIN=InstrReg.
  - The immediate must be present in the first EXEC cycle, which is processor T1.
  - Done=1 in any EXEC cycle:
    - PC<=PC+2 for mvi, else PC+1 (modulo 2^ADDR_W).
    - InstrCount<=InstrCount+1 (wraps).
    - Go to FETCH.
  - Done=0: watchdog increments; when it reaches TIMEOUT, go to ERROR with PC unchanged.
- Expected Done position within EXEC: cycle 1 for mv/mvi, cycle 2 for ones, cycle 3 for add/sub.
- Done outside EXEC is ignored.
- Run is never asserted outside ISSUE, so the processor sits in T0 during FETCH/LOAD/PRE.
- Start while Busy is ignored.
- Simultaneous Done and watchdog expiry in the same cycle: Done wins.
- Issue-to-issue spacing is fixed at 3 cycles (FETCH, LOAD, PRE) plus the EXEC length.

Decomposition:
- Shared package holds:
  - opcode constants OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_ONES, OP_HALT;
  - the state enumeration;
  - the word width constant 9.
- No sub-module; the watchdog counter is inline.

Test Plan:
- Program at 0: mvi R0 (001000000), #5 (000000101), HALT (111000000); Start with StartAddr=0, Done model pulses in EXEC cycle 1:
  - one Run pulse with DIN=9'o100; next cycle DIN=9'd5;
  - then Halted=1, PC=2, InstrCount=1.
- add R1,R2 (9'o212), then HALT; Done in EXEC cycle 3:
  - Run 1 cycle; Busy through 3 EXEC cycles;
  - PC=1 at HALT; InstrCount=1.
- Done tied low, program mv R0,R1 (9'o001):
  - Error=1 exactly TIMEOUT(8) cycles after leaving ISSUE; no second Run pulse.
- Word 9'o500 at StartAddr=3:
  - Error=1 after PRE; Run never asserted; PC=3.
- ADDR_W=7, StartAddr=127 holding mvi, immediate at address 0, HALT at 1:
  - immediate is read from MemAddr=0; Halted with PC=1.
- Mid-EXEC checks:
  - Resetn low: all outputs return to reset values immediately and IDLE is held.
  - Start pulsed while Busy: ignored, PC unaffected.

Source files
------------

// File: rtl/proc_sequencer_pkg.sv
// Shared definitions for the 9-bit bus processor instruction sequencer.
//   WORD_W   : width of a program / bus word (9)
//   OP_*     : opcode field values found in IR[8:6]
//   state_t  : sequencer state encoding
package proc_sequencer_pkg;

  localparam int WORD_W = 9;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_ONES = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_PRE    = 3'd3,
    S_ISSUE  = 3'd4,
    S_EXEC   = 3'd5,
    S_HALTED = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

endpackage

// File: rtl/proc_sequencer.sv
// Instruction issuer for the 9-bit bus processor (initiator side of the
// DIN/Run/Done handshake). Fetches words from a synchronous-read program
// memory, issues each instruction with a one-cycle Run pulse, supplies the
// mvi immediate during the first execute cycle, waits for Done and advances
// the PC. Stops on HALT, flags Error on illegal opcodes or a Done timeout.
//
// Ports:
//   Clock       in   system clock, rising edge
//   Resetn      in   asynchronous active-low reset
//   Start       in   begin execution at StartAddr (only when not busy)
//   StartAddr   in   [ADDR_W] initial program counter
//   MemAddr     out  [ADDR_W] program memory read address
//   MemData     in   [9] program word, valid one cycle after MemAddr
//   DIN         out  [9] registered instruction / immediate word
//   Run         out  one-cycle issue strobe
//   Done        in   processor completion (combinational)
//   Busy        out  high in FETCH/LOAD/PRE/ISSUE/EXEC
//   Halted      out  high in HALTED
//   Error       out  high in ERROR
//   PC          out  [ADDR_W] current program counter
//   InstrCount  out  [CNT_W] instructions retired since the last Start
module proc_sequencer
  import proc_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [WORD_W-1:0] MemData,
  output logic [WORD_W-1:0] DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [ADDR_W-1:0] PC,
  output logic [CNT_W-1:0]  InstrCount
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t              r_state;
  state_t              w_next;
  logic [WORD_W-1:0]   r_instr;
  logic [WORD_W-1:0]   r_imm;
  logic [WORD_W-1:0]   r_din;
  logic                r_run;
  logic [ADDR_W-1:0]   r_pc;
  logic [CNT_W-1:0]    r_cnt;
  logic [WD_W-1:0]     r_wd;
  logic [2:0]          w_op;
  logic                w_is_mvi;
  logic                w_wd_expire;

  assign w_op        = r_instr[WORD_W-1:WORD_W-3];
  assign w_is_mvi    = (w_op == OP_MVI);
  // Expiry is judged on the count before this cycle's increment, so the
  // TIMEOUT-th Done-less EXEC cycle is the last one tolerated.
  assign w_wd_expire = (r_wd == WD_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_HALTED, S_ERROR: if (Start) w_next = S_FETCH;
      S_FETCH: w_next = S_LOAD;
      S_LOAD:  w_next = S_PRE;
      S_PRE: begin
        case (w_op)
          OP_HALT:        w_next = S_HALTED;
          3'b101, 3'b110: w_next = S_ERROR;
          default:        w_next = S_ISSUE;
        endcase
      end
      S_ISSUE: w_next = S_EXEC;
      S_EXEC: begin
        // Done takes priority over a simultaneous watchdog expiry.
        if (Done)             w_next = S_FETCH;
        else if (w_wd_expire) w_next = S_ERROR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_instr <= '0;
      r_imm   <= '0;
      r_din   <= '0;
      r_run   <= 1'b0;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_wd    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_HALTED, S_ERROR: begin
          if (Start) begin
            r_pc  <= StartAddr;
            r_cnt <= '0;
          end
        end
        S_LOAD: r_instr <= MemData;
        S_PRE: begin
          r_imm <= MemData;
          // DIN and Run are registered, so they are loaded on entry to ISSUE.
          if (w_next == S_ISSUE) begin
            r_din <= r_instr;
            r_run <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_run <= 1'b0;
          r_wd  <= '0;
          // The immediate must already be on DIN in the first EXEC cycle.
          r_din <= w_is_mvi ? r_imm : r_instr;
        end
        S_EXEC: begin
          if (Done) begin
            r_pc  <= r_pc + (w_is_mvi ? ADDR_W'(2) : ADDR_W'(1));
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // LOAD reads the word after the instruction so the immediate arrives in PRE.
  assign MemAddr    = (r_state == S_LOAD) ? r_pc + ADDR_W'(1) : r_pc;
  assign DIN        = r_din;
  assign Run        = r_run;
  assign PC         = r_pc;
  assign InstrCount = r_cnt;
  assign Busy       = (r_state == S_FETCH) || (r_state == S_LOAD) ||
                      (r_state == S_PRE)   || (r_state == S_ISSUE) ||
                      (r_state == S_EXEC);
  assign Halted     = (r_state == S_HALTED);
  assign Error      = (r_state == S_ERROR);

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed self-checking bench for proc_sequencer: synchronous program
// memory model plus a processor Done model that answers a fixed number of
// cycles after each Run pulse.
module tb_proc_sequencer;

  localparam int ADDR_W  = 7;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 16;

  logic              Clock;
  logic              Resetn;
  logic              Start;
  logic [ADDR_W-1:0] StartAddr;
  logic [ADDR_W-1:0] MemAddr;
  logic [8:0]        MemData;
  logic [8:0]        DIN;
  logic              Run;
  logic              Done;
  logic              Busy;
  logic              Halted;
  logic              Error;
  logic [ADDR_W-1:0] PC;
  logic [CNT_W-1:0]  InstrCount;

  logic [8:0] mem [0:(1<<ADDR_W)-1];
  int exec_cnt;
  int done_lat;
  int run_cnt;
  int tests;
  int fails;
  int run_snap;

  proc_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .StartAddr(StartAddr),
    .MemAddr(MemAddr), .MemData(MemData), .DIN(DIN), .Run(Run), .Done(Done),
    .Busy(Busy), .Halted(Halted), .Error(Error), .PC(PC),
    .InstrCount(InstrCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) MemData <= mem[MemAddr];

  // Processor model: exec_cnt is 1 in the first EXEC cycle after Run.
  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn)                            exec_cnt <= 0;
    else if (Run === 1'b1)                  exec_cnt <= 1;
    else if (exec_cnt != 0 && exec_cnt < 100) exec_cnt <= exec_cnt + 1;
  end
  assign Done = (done_lat != 0) && (exec_cnt == done_lat);

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn)           run_cnt <= 0;
    else if (Run === 1'b1) run_cnt <= run_cnt + 1;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] a);
    Start = 1'b1;
    StartAddr = a;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    Resetn = 1'b0; Start = 1'b0; StartAddr = '0; done_lat = 1;
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 9'o000;
    tick(); tick();
    chk("rst_busy", Busy, 0);
    chk("rst_run", Run, 0);
    Resetn = 1'b1;
    tick();
    chk("idle_busy", Busy, 0);
    chk("idle_halted", Halted, 0);
    chk("idle_error", Error, 0);
    chk("idle_pc", PC, 0);
    chk("idle_din", DIN, 0);
    chk("idle_memaddr", MemAddr, 0);
    chk("idle_cnt", InstrCount, 0);

    // mvi R0,#5 ; HALT
    mem[0] = 9'o100; mem[1] = 9'o005; mem[2] = 9'o700; done_lat = 1;
    do_start(0);
    chk("t1_fetch_busy", Busy, 1);
    chk("t1_fetch_addr", MemAddr, 0);
    tick();
    chk("t1_load_addr", MemAddr, 1);
    chk("t1_load_run", Run, 0);
    tick();
    chk("t1_pre_run", Run, 0);
    tick();
    chk("t1_issue_run", Run, 1);
    chk("t1_issue_din", DIN, 9'o100);
    tick();
    chk("t1_exec_run", Run, 0);
    chk("t1_exec_din", DIN, 9'd5);
    chk("t1_exec_done", Done, 1);
    tick();
    chk("t1_pc_adv", PC, 2);
    tick(); tick(); tick();
    chk("t1_halted", Halted, 1);
    chk("t1_busy", Busy, 0);
    chk("t1_pc", PC, 2);
    chk("t1_cnt", InstrCount, 1);
    chk("t1_runs", run_cnt, 1);

    // add R1,R2 ; HALT, Done in EXEC cycle 3
    mem[0] = 9'o212; mem[1] = 9'o700; done_lat = 3;
    do_start(0);
    chk("t2_cnt_clr", InstrCount, 0);
    tick(); tick(); tick();
    chk("t2_issue_run", Run, 1);
    chk("t2_issue_din", DIN, 9'o212);
    tick();
    chk("t2_e1_busy", Busy, 1);
    chk("t2_e1_run", Run, 0);
    chk("t2_e1_din", DIN, 9'o212);
    tick();
    chk("t2_e2_busy", Busy, 1);
    chk("t2_e2_pc", PC, 0);
    tick();
    chk("t2_e3_busy", Busy, 1);
    chk("t2_e3_done", Done, 1);
    tick(); tick(); tick(); tick();
    chk("t2_halted", Halted, 1);
    chk("t2_pc", PC, 1);
    chk("t2_cnt", InstrCount, 1);
    chk("t2_runs", run_cnt, 2);

    // mv R0,R1 with Done never arriving: watchdog timeout
    mem[0] = 9'o001; done_lat = 0;
    do_start(0);
    tick(); tick(); tick();
    chk("t3_issue_run", Run, 1);
    for (int j = 1; j <= TIMEOUT; j++) begin
      tick();
      chk("t3_exec_busy", Busy, 1);
      chk("t3_exec_noerr", Error, 0);
    end
    tick();
    chk("t3_error", Error, 1);
    chk("t3_busy", Busy, 0);
    chk("t3_pc", PC, 0);
    chk("t3_runs", run_cnt, 3);

    // Illegal opcode 101 at address 3
    mem[3] = 9'o500; done_lat = 1;
    run_snap = run_cnt;
    do_start(3);
    tick(); tick();
    chk("t4_pre_busy", Busy, 1);
    tick();
    chk("t4_error", Error, 1);
    chk("t4_pc", PC, 3);
    chk("t4_no_run", run_cnt, run_snap);

    // PC wrap: mvi at 127, immediate at 0, HALT at 1
    mem[127] = 9'o100; mem[0] = 9'o077; mem[1] = 9'o700; done_lat = 1;
    do_start(127);
    chk("t5_fetch_addr", MemAddr, 127);
    tick();
    chk("t5_load_addr", MemAddr, 0);
    tick(); tick();
    chk("t5_issue_din", DIN, 9'o100);
    tick();
    chk("t5_exec_din", DIN, 9'o077);
    tick(); tick(); tick(); tick();
    chk("t5_halted", Halted, 1);
    chk("t5_pc", PC, 1);
    chk("t5_cnt", InstrCount, 1);

    // Done arriving in the last allowed EXEC cycle beats the watchdog
    mem[0] = 9'o001; mem[1] = 9'o700; done_lat = TIMEOUT;
    do_start(0);
    for (int j = 0; j < 3 + TIMEOUT; j++) tick();
    chk("t6_last_done", Done, 1);
    chk("t6_last_busy", Busy, 1);
    tick(); tick(); tick(); tick();
    chk("t6_halted", Halted, 1);
    chk("t6_noerr", Error, 0);
    chk("t6_cnt", InstrCount, 1);

    // Start while busy is ignored, then reset mid-EXEC
    mem[20] = 9'o212; mem[21] = 9'o700; done_lat = 3;
    do_start(20);
    tick(); tick(); tick(); tick();
    chk("t7_e1_busy", Busy, 1);
    Start = 1'b1; StartAddr = 50;
    tick();
    Start = 1'b0;
    chk("t7_ign_pc", PC, 20);
    chk("t7_ign_busy", Busy, 1);
    run_snap = run_cnt;
    Resetn = 1'b0;
    #1;
    chk("t7_rst_busy", Busy, 0);
    chk("t7_rst_pc", PC, 0);
    chk("t7_rst_din", DIN, 0);
    chk("t7_rst_addr", MemAddr, 0);
    chk("t7_rst_run", Run, 0);
    chk("t7_rst_halt", Halted, 0);
    chk("t7_rst_err", Error, 0);
    tick(); tick();
    chk("t7_hold_busy", Busy, 0);
    chk("t7_hold_run", Run, 0);
    Resetn = 1'b1;
    tick(); tick();
    chk("t7_idle_busy", Busy, 0);
    chk("t7_idle_cnt", InstrCount, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
